// File: rtl/mpcr_pkg.sv
// Shared types and the per-limb carry-correction helper for mp_carry_resolver.
// Optional frame check is enabled with MPCR_FRAME_CHECK_EN (used by the other files).
package mpcr_pkg;

   localparam int LIMB_W = 64;
   localparam logic [LIMB_W-1:0] LIMB_ONES = '1;

   typedef enum logic {COLLECT, DONE} state_t;

   // Adds the incoming carry to a limb the adder produced with carry-in 0.
   // The resolved carry-out is the adder's own carry or the ripple through an all-ones limb.
   function automatic logic [LIMB_W:0] carry_fix(input logic [LIMB_W-1:0] sum,
                                                 input logic              cin,
                                                 input logic              cout);
      logic [LIMB_W-1:0] limb;
      logic              cres;
      limb = sum + {{(LIMB_W-1){1'b0}}, cin};
      cres = cout | (cin & (sum == LIMB_ONES));
      return {cres, limb};
   endfunction

endpackage

// File: rtl/mp_carry_resolver_if.sv
// Limb-stream input and packed-sum output handshake of mp_carry_resolver.
// s_last/err exist only when MPCR_FRAME_CHECK_EN is defined.
interface mp_carry_resolver_if #(parameter int NUM_LIMBS = 4);
   import mpcr_pkg::*;

   logic                        s_valid;
   logic                        s_ready;
   logic [LIMB_W-1:0]           s_sum;
   logic                        s_carry;
   logic                        m_valid;
   logic                        m_ready;
   logic [LIMB_W*NUM_LIMBS-1:0] m_data;
   logic                        m_carry;
`ifdef MPCR_FRAME_CHECK_EN
   logic                        s_last;
   logic                        err;
`endif

   modport slave (
      input  s_valid, s_sum, s_carry, m_ready,
      output s_ready, m_valid, m_data, m_carry
`ifdef MPCR_FRAME_CHECK_EN
      , input s_last, output err
`endif
   );

   modport master (
      output s_valid, s_sum, s_carry, m_ready,
      input  s_ready, m_valid, m_data, m_carry
`ifdef MPCR_FRAME_CHECK_EN
      , output s_last, input err
`endif
   );

endinterface

// File: rtl/mpcr_limb_fix.sv
// Combinational correction of one limb: adds the running carry and resolves carry-out.
module mpcr_limb_fix
   import mpcr_pkg::*;
(
   input  logic [LIMB_W-1:0] sum,
   input  logic              cin,
   input  logic              cout,
   output logic [LIMB_W-1:0] limb,
   output logic              cres
);

   assign {cres, limb} = carry_fix(sum, cin, cout);

endmodule

// File: rtl/mp_carry_resolver.sv
// Serially resolves inter-limb carries and packs NUM_LIMBS limbs into one wide sum.
// Define MPCR_FRAME_CHECK_EN to add s_last framing and the err pulse.
module mp_carry_resolver
   import mpcr_pkg::*;
#(
   parameter int NUM_LIMBS = 4,
   parameter int CNT_W     = $clog2(NUM_LIMBS)
) (
   input logic                  clk,
   input logic                  rst_n,
   mp_carry_resolver_if.slave   bus
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_LIMBS - 1);

   state_t                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        c_q, c_d;
   logic                        carry_q, carry_d;
   logic [LIMB_W*NUM_LIMBS-1:0] data_q;
   logic                        accept;
   logic                        last_cnt;
   logic                        drop;
   logic [LIMB_W-1:0]           fixed_limb;
   logic                        fixed_c;

   mpcr_limb_fix u_fix (
      .sum  (bus.s_sum),
      .cin  (c_q),
      .cout (bus.s_carry),
      .limb (fixed_limb),
      .cres (fixed_c)
   );

   assign accept   = bus.s_valid && (state_q == COLLECT);
   assign last_cnt = (cnt_q == LAST_CNT);

`ifdef MPCR_FRAME_CHECK_EN
   logic err_q;

   // An early s_last abandons the frame; a missing one only raises err.
   assign drop = accept && bus.s_last && !last_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= accept && (bus.s_last != last_cnt);
      end
   end

   assign bus.err = err_q;
`else
   assign drop = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      carry_d = carry_q;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (drop) begin
                  cnt_d = '0;
                  c_d   = 1'b0;
               end else if (last_cnt) begin
                  carry_d = fixed_c;
                  state_d = DONE;
                  cnt_d   = '0;
                  c_d     = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  c_d   = fixed_c;
               end
            end
         end
         DONE: begin
            if (bus.m_ready) begin
               state_d = COLLECT;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         carry_q <= carry_d;
      end
   end

   // Each corrected limb lands in the slot selected by the limb counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         for (int i = 0; i < NUM_LIMBS; i++) begin
            if (accept && !drop && (cnt_q == CNT_W'(i))) begin
               data_q[i*LIMB_W +: LIMB_W] <= fixed_limb;
            end
         end
      end
   end

   assign bus.s_ready = (state_q == COLLECT);
   assign bus.m_valid = (state_q == DONE);
   assign bus.m_data  = data_q;
   assign bus.m_carry = carry_q;

endmodule

// File: doc/mp_carry_resolver.md
# mp_carry_resolver

Downstream stage of the 64-bit registered adder. It takes the adder's per-limb `result`/`carry` stream, which the adder computes with carry-in fixed at 0, and resolves carries across limbs serially, least-significant limb first. It packs the limbs into one NUM_LIMBS×64-bit multi-precision sum and holds that sum behind a valid/ready output handshake. This turns the single-word adder into a wide (default 256-bit) adder datapath.

## Interface
- NUM_LIMBS, 4, limbs per operand (≥2); output width W = 64·NUM_LIMBS
- CNT_W, $clog2(NUM_LIMBS), limb counter width
- Clocking: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.
- clk  in  1  rising-edge clock, shared with the adder
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  limb present on s_sum/s_carry
- s_ready  out  1  block accepts a limb this cycle
- s_sum  in  64  adder `result` for the current limb
- s_carry  in  1  adder `carry` for the current limb
- s_last  in  1  last limb of frame (present only with MPCR_FRAME_CHECK_EN)
- m_valid  out  1  packed sum available
- m_ready  in  1  consumer takes the packed sum
- m_data  out  W  resolved sum; limb i occupies bits [64i+63:64i]
- m_carry  out  1  carry-out of the full W-bit addition
- err  out  1  frame-length error pulse (present only with MPCR_FRAME_CHECK_EN)

## Operation
- States: COLLECT (accepting limbs), DONE (holding output).
- s_ready = (state == COLLECT); m_valid = (state == DONE).
- A limb is accepted when s_valid && s_ready. Per accepted limb i, with running carry c (0 at frame start):
  - limb_i = s_sum + c, mod 2^64
  - c_next = s_carry | (c & (s_sum == 64'hFFFF_FFFF_FFFF_FFFF))
  - limb_i is written into its m_data slot; cnt increments; c ← c_next
- When the limb with cnt == NUM_LIMBS−1 is accepted: m_carry ← c_next, state → DONE, cnt ← 0, c ← 0.
- DONE: m_data and m_carry hold stable until m_valid && m_ready, then state → COLLECT.
- s_valid low in COLLECT: nothing changes; gaps between limbs are allowed.
- Reset mid-frame: the partial frame is discarded; no output is produced for it.
- Reset values: state COLLECT, cnt 0, c 0, m_valid 0, s_ready 1 (after the state register settles), m_data 0, m_carry 0, err 0.

## Timing
- Throughput: one limb per cycle in COLLECT.
- m_valid rises the cycle after the last limb is accepted.
- s_ready is low for every DONE cycle. The earliest the next frame's first limb is accepted is the cycle after the m_valid/m_ready handshake. Back-to-back frames therefore cost NUM_LIMBS+1 cycles each.
- No combinational path from m_ready to s_ready, or from s_valid to m_valid.
- Carry correction stays on the limb-accept cycle: one 64-bit increment plus a 64-bit all-ones compare.

## Configuration
- MPCR_FRAME_CHECK_EN defined:
  - The s_last and err ports exist.
  - err pulses high for one cycle when s_last is accepted with cnt ≠ NUM_LIMBS−1, or when the limb with cnt == NUM_LIMBS−1 is accepted with s_last = 0.
  - On an early s_last the frame is dropped: return to COLLECT, cnt 0, c 0, m_valid not raised.
  - On a missing s_last the frame completes normally and err is still flagged.
- MPCR_FRAME_CHECK_EN not defined: neither port exists, and frames are delimited purely by counting NUM_LIMBS limbs.

## Structure
- Shared package mpcr_pkg holds:
  - LIMB_W = 64
  - the state enum {COLLECT, DONE}
  - LIMB_ONES constant
  - function carry_fix(sum, cin, cout) returning {cout_resolved, limb}
- One sub-module, mpcr_limb_fix, is natural: the combinational per-limb correction (sum + c, resolved carry). It is reusable if the resolver is later unrolled.
- The FSM, counter and output register stay in the top module.

## Test plan
- No overflow: 4 limbs s_sum=1,2,3,4, s_carry=0, m_ready=1 → m_data = {4,3,2,1}, m_carry=0, m_valid high for one cycle.
- Ripple: limb0 s_sum=0, s_carry=1; limbs1–3 s_sum=64'hFFFF_FFFF_FFFF_FFFF, s_carry=0 → m_data = {0,0,0,0}, m_carry=1.
- Backpressure: complete a frame with m_ready=0 for 5 cycles → m_data stable and s_ready=0 throughout. m_ready=1 → s_ready=1 on the next cycle, and a second frame is accepted correctly.
- Gaps: s_valid toggled 1,0,0,1,1,0,1 over one frame → same result as the gap-free frame; cnt advances only on accepts.
- Reset mid-frame: rst_n low after 2 limbs, then a fresh 4-limb frame → only the fresh frame's sum appears; carry from the aborted frame does not leak into it.
- MPCR_FRAME_CHECK_EN: s_last on limb 1 → one-cycle err pulse, no m_valid, next frame correct. s_last absent on limb 3 → err pulse plus a normal m_valid.
